// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Cleans up three raw, asynchronous, bouncy push buttons before they reach
//   the LED sequence FSM. Each channel works on its own. It synchronises the
//   raw input with a two-flop chain. It then debounces the synchronised value
//   with a stability counter. Finally it presents a clean level and a
//   one-cycle pulse on every accepted press (0->1).
//
// Ports:
//   CLK      in   system clock, all state updates on the rising edge
//   RST      in   asynchronous, active-high reset
//   A_RAW    in   raw button A (asynchronous to CLK)
//   B_RAW    in   raw button B (asynchronous to CLK)
//   C_RAW    in   raw button C (asynchronous to CLK)
//   A, B, C  out  debounced levels (drive FSM.A / FSM.B / FSM.C)
//   A_PULSE  out  one-cycle pulse when A rises
//   B_PULSE  out  one-cycle pulse when B rises
//   C_PULSE  out  one-cycle pulse when C rises
//
// Timing:
//   Suppose a raw input changes and stays stable from before edge k.
//   The synchronised copy changes at edge k+1.
//   The clean level (and the pulse, on a rise) changes at edge
//   k+1+DEBOUNCE_CYCLES.
//   Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_RAW,
    input  logic B_RAW,
    input  logic C_RAW,
    output logic A,
    output logic B,
    output logic C,
    output logic A_PULSE,
    output logic B_PULSE,
    output logic C_PULSE
);

    localparam int NCH = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel index: 0 = A, 1 = B, 2 = C.
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   lvl_q;
    logic [NCH-1:0]   lvl_d;
    logic [NCH-1:0]   pulse_q;
    logic [NCH-1:0]   pulse_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    assign raw = {C_RAW, B_RAW, A_RAW};

    // Two-flop synchroniser. Only s2_q is used downstream.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce next-state logic. The counter measures how long s2 has
    // disagreed with the clean level. Any agreement resets it, so the
    // disagreement has to be uninterrupted. The level flips on the cycle the
    // counter would reach DEBOUNCE_CYCLES, so the counter never passes
    // CNT_MAX and never wraps.
    always_comb begin
        lvl_d   = lvl_q;
        pulse_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    lvl_d[i]   = s2_q[i];
                    // The pulse is registered with the level, so both
                    // appear on the same edge. A release never pulses.
                    pulse_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_q   <= '0;
            pulse_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign A       = lvl_q[0];
    assign B       = lvl_q[1];
    assign C       = lvl_q[2];
    assign A_PULSE = pulse_q[0];
    assign B_PULSE = pulse_q[1];
    assign C_PULSE = pulse_q[2];

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Exercises button_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs are driven right after a falling edge. The stimulus then waits for
// the next rising edge and samples at the falling edge that follows.
// So "edge n" means the outputs after the n-th rising edge. That edge saw the
// inputs applied just before it.
// For inputs held stable for at least 4 cycles, the clean level at edge n
// equals the raw value applied before edge n-5.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic CLK = 1'b0;
    logic RST;
    logic A_RAW, B_RAW, C_RAW;
    logic A, B, C;
    logic A_PULSE, B_PULSE, C_PULSE;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .A_RAW   (A_RAW),
        .B_RAW   (B_RAW),
        .C_RAW   (C_RAW),
        .A       (A),
        .B       (B),
        .C       (C),
        .A_PULSE (A_PULSE),
        .B_PULSE (B_PULSE),
        .C_PULSE (C_PULSE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- vector table ----------------
    // raw / lvl / pls bit order is {A, B, C}.
    typedef struct {
        logic       rst;
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] pls;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic rst, logic [2:0] raw,
                                logic [2:0] lvl, logic [2:0] pls);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{rst, raw, lvl, pls});
        end
    endfunction

    // ---------------- driver / checker ----------------
    task automatic drive(logic rst, logic [2:0] raw);
        RST = rst;
        {A_RAW, B_RAW, C_RAW} = raw;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(string name, logic [2:0] lvl_e, logic [2:0] pls_e);
        checks++;
        if ({A, B, C} !== lvl_e || {A_PULSE, B_PULSE, C_PULSE} !== pls_e) begin
            failures++;
            $display("FAIL %s: got lvl=%b pulse=%b, expected lvl=%b pulse=%b",
                     name, {A, B, C}, {A_PULSE, B_PULSE, C_PULSE}, lvl_e, pls_e);
        end
    endtask

    // ---------------- delay model for stable (>=4 cycle) inputs ----------------
    logic [2:0] hist[$];
    logic [2:0] prev_exp;
    int         b_pulses;

    task automatic model_reset(logic [2:0] settled);
        hist = {};
        for (int i = 0; i < 5; i++) hist.push_back(settled);
        prev_exp = settled;
        b_pulses = 0;
    endtask

    task automatic run_model(string name, logic [2:0] raw, int n);
        logic [2:0] exp_lvl;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, raw);
            hist.push_back(raw);
            exp_lvl = hist[0];
            void'(hist.pop_front());
            check($sformatf("%s[%0d]", name, i), exp_lvl, exp_lvl & ~prev_exp);
            prev_exp = exp_lvl;
            if (B_PULSE === 1'b1) b_pulses++;
        end
    endtask

    // ---------------- test ----------------
    logic [0:18] b_pat;

    initial begin
        RST = 1'b1;
        {A_RAW, B_RAW, C_RAW} = 3'b111;

        // Reset held with all buttons pressed, then released.
        add(10, 1'b1, 3'b111, 3'b000, 3'b000);
        add(5,  1'b0, 3'b111, 3'b000, 3'b000);
        add(1,  1'b0, 3'b111, 3'b111, 3'b111);
        add(2,  1'b0, 3'b111, 3'b111, 3'b000);
        // All released: the levels drop 5 edges later with no pulse.
        add(5,  1'b0, 3'b000, 3'b111, 3'b000);
        add(3,  1'b0, 3'b000, 3'b000, 3'b000);
        // Clean press on C.
        add(5,  1'b0, 3'b001, 3'b000, 3'b000);
        add(1,  1'b0, 3'b001, 3'b001, 3'b001);
        add(3,  1'b0, 3'b001, 3'b001, 3'b000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].raw);
            check($sformatf("vec[%0d]", i), vecs[i].lvl, vecs[i].pls);
        end

        // Asynchronous reset: C is high here and must clear with no edge.
        RST = 1'b1;
        #1;
        check("async_reset", 3'b000, 3'b000);
        drive(1'b1, 3'b000);
        drive(1'b1, 3'b000);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'b000);
            check($sformatf("settle[%0d]", i), 3'b000, 3'b000);
        end

        // Bounce: B toggles, then a 3-cycle-high glitch. Both must be rejected.
        b_pat = 19'b1010_0011_1000_0000_000;
        for (int i = 0; i < 19; i++) begin
            drive(1'b0, {1'b0, b_pat[i], 1'b0});
            check($sformatf("bounce[%0d]", i), 3'b000, 3'b000);
        end

        // A glitch exactly 4 cycles long is accepted.
        model_reset(3'b000);
        run_model("glitch4_hi", 3'b010, 4);
        run_model("glitch4_lo", 3'b000, 12);

        // FSM-style: three presses of B, 10 cycles per phase.
        model_reset(3'b000);
        for (int p = 0; p < 3; p++) begin
            run_model($sformatf("fsm_press%0d", p), 3'b010, 10);
            run_model($sformatf("fsm_rel%0d", p), 3'b000, 10);
        end
        checks++;
        if (b_pulses != 3) begin
            failures++;
            $display("FAIL fsm_pulse_count: got %0d, expected 3", b_pulses);
        end

        // Independence: A and C pressed together, then only A released.
        model_reset(3'b000);
        run_model("ac_press", 3'b101, 10);
        run_model("a_release", 3'b001, 10);
        run_model("c_release", 3'b000, 10);

        // Reset mid-count: B is partly counted when reset hits.
        drive(1'b0, 3'b010);  // edge k
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b010);
            check($sformatf("midcnt_pre[%0d]", i), 3'b000, 3'b000);
        end
        drive(1'b1, 3'b010);
        check("midcnt_rst", 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'b010);
            check($sformatf("midcnt_post[%0d]", i), 3'b000, 3'b000);
        end
        drive(1'b0, 3'b010);
        check("midcnt_rise", 3'b010, 3'b010);
        drive(1'b0, 3'b010);
        check("midcnt_hold", 3'b010, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the LED sequence FSM and drives its A, B and C inputs.
- Takes three raw, asynchronous, bouncy push-button signals and, for each one:
  - synchronizes it into the CLK domain;
  - debounces it with a per-button stability counter;
  - presents a clean level and a single-cycle rising-edge pulse.
- The FSM consumes the clean levels; the pulses are available to any press-counting logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized input must differ from the current clean level before the level flips (legal range 1..65535).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- A_RAW  input  1  raw button A, asynchronous to CLK.
- B_RAW  input  1  raw button B, asynchronous to CLK.
- C_RAW  input  1  raw button C, asynchronous to CLK.
- A  output  1  debounced level of button A (to FSM.A).
- B  output  1  debounced level of button B (to FSM.B).
- C  output  1  debounced level of button C (to FSM.C).
- A_PULSE  output  1  one-cycle pulse on A rising (0->1).
- B_PULSE  output  1  one-cycle pulse on B rising.
- C_PULSE  output  1  one-cycle pulse on C rising.

Behaviour:
- Reset (RST=1, asynchronous): clears all synchronizer flops, counters, clean levels and pulse flops.
  - A=B=C=0, A_PULSE=B_PULSE=C_PULSE=0 immediately.
  - Outputs hold at 0 while RST is high.
- Channels: the three channels are identical and fully independent. Simultaneous activity on several channels is handled per channel with no priority or interaction.
- Synchronizer, per channel:
  - Two-flop chain: s1 <= RAW, s2 <= s1.
  - Only s2 is used downstream.
- Debounce, per channel; state is the counter cnt (CNT_W bits) and the clean level lvl:
  - s2 == lvl: cnt <= 0 (any bounce back restarts the count).
  - s2 != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s2, cnt <= 0.
  - s2 != lvl otherwise: cnt <= cnt+1.
  - cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- Pulse, per channel:
  - X_PULSE <= 1 on the same edge where lvl goes 0->1; otherwise X_PULSE <= 0.
  - Pulse and level rise together; the pulse lasts exactly one cycle.
  - No pulse on a 1->0 release.
- Latency: RAW changes and is held stable from before edge k.
  - s2 updates at edge k+1.
  - lvl (and the pulse, on a rise) updates at edge k+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4: 5 edges.
- Glitch rejection:
  - A RAW excursion whose s2 image lasts fewer than DEBOUNCE_CYCLES consecutive cycles never changes lvl and never pulses.
  - A glitch exactly DEBOUNCE_CYCLES long is accepted.
- Held button: lvl stays 1 indefinitely and the pulse fires only once per accepted press.
- Reset mid-count:
  - The count is lost.
  - After RST deasserts with RAW held high, a full synchronizer plus DEBOUNCE_CYCLES delay is required before lvl rises.
  - That rise produces a fresh pulse.
- DEBOUNCE_CYCLES=1: lvl follows s2 one cycle later (pure 3-flop delay with edge pulse).
- Outputs are registered; there are no combinational paths from any input to any output.

Test Plan:
- Reset values: RST=1 with all RAW=1 for 10 cycles -> A=B=C=0 and all pulses 0 throughout. Release RST -> A rises exactly 5 edges later, with a single A_PULSE.
- Clean press (DEBOUNCE_CYCLES=4): C_RAW 0->1 held before edge k -> C=1 and C_PULSE=1 at edge k+5 only. C_PULSE=0 at k+6 and beyond while C stays 1.
- Bounce rejection: B_RAW toggles 1,0,1,0 each cycle, then a 3-cycle-high glitch -> B stays 0 and B_PULSE never fires.
- FSM-style sequence: B_RAW pressed and released 3 times, each phase held 10 cycles -> exactly 3 B_PULSE pulses, with B a clean copy delayed 5 cycles.
- Release and independence:
  - A_RAW and C_RAW rise on the same cycle -> A_PULSE and C_PULSE fire on the same edge.
  - A_RAW then falls -> A drops 5 edges later with no pulse, and C is unaffected.
- Reset mid-count: B_RAW high for 2 cycles past synchronization, then RST pulsed 1 cycle while B_RAW stays high -> B rises 5 edges after RST release, with one B_PULSE.
